seg7_scan_driver: RTL

//  Downstream display stage for the BCD/hex digit counter.
//  - Takes NUM_DIGITS 4-bit digit codes plus decimal points, latches them tear-free at frame boundaries.
//  - Time-multiplexes the digits onto one common 7-segment bus with one-hot digit enables.
//  - Adds leading-zero blanking and 4-bit PWM brightness.
//  - Outputs drive the uo_out/uio_out pins at the top level.

---
 rtl/seg7_scan_driver.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed 7-segment scan driver with tear-free load, blanking and PWM
//
// Purpose: latches NUM_DIGITS hex digit codes and decimal points at frame
// boundaries and scans them onto one common 7-segment bus, one digit slot of
// SCAN_DIV cycles at a time, with optional leading-zero blanking and 4-bit PWM
// brightness. All display outputs are registered (one cycle latency).
//
// Ports:
//   clk         system clock
//   rst_n       synchronous reset, active-low
//   digits_in   digit codes, [3:0] = digit 0 (rightmost)
//   dp_in       decimal point per digit, 1 = lit
//   load        1-cycle strobe sampling digits_in/dp_in into the pending buffer
//   lz_blank    1 = blank leading zeros (digit 0 never blanked, dp never blanked)
//   brightness  0 = dark .. 15 = full on
//   seg         segments {g,f,e,d,c,b,a}, active-high
//   dp          decimal point of the current digit, active-high
//   dig_en      one-hot digit enable, active-high
//   frame_done  1-cycle pulse the cycle after the last slot of a frame ends
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 10000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_blank,
  input  logic [3:0]              brightness,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int DW    = 4 * NUM_DIGITS;

  logic [CNT_W-1:0]      slot_cnt;
  logic [3:0]            pwm_cnt;
  logic [IDX_W-1:0]      idx;

  logic [DW-1:0]         pend_digits;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic                  pending_valid;
  logic [DW-1:0]         act_digits;
  logic [NUM_DIGITS-1:0] act_dp;

  logic                  slot_end;
  logic                  fb;
  logic                  pwm_on;
  logic [3:0]            cur_digit;
  logic [DW-1:0]         digits_from_idx;
  logic                  blank;
  logic [6:0]            seg_nxt;
  logic                  dp_nxt;
  logic [NUM_DIGITS-1:0] dig_en_nxt;

  function automatic logic [6:0] seg7_decode(input logic [3:0] d);
    case (d)
      4'h0: seg7_decode = 7'h3F;
      4'h1: seg7_decode = 7'h06;
      4'h2: seg7_decode = 7'h5B;
      4'h3: seg7_decode = 7'h4F;
      4'h4: seg7_decode = 7'h66;
      4'h5: seg7_decode = 7'h6D;
      4'h6: seg7_decode = 7'h7D;
      4'h7: seg7_decode = 7'h07;
      4'h8: seg7_decode = 7'h7F;
      4'h9: seg7_decode = 7'h6F;
      4'hA: seg7_decode = 7'h77;
      4'hB: seg7_decode = 7'h7C;
      4'hC: seg7_decode = 7'h39;
      4'hD: seg7_decode = 7'h5E;
      4'hE: seg7_decode = 7'h79;
      default: seg7_decode = 7'h71;
    endcase
  endfunction

  always_comb begin
    slot_end = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    fb       = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
    pwm_on   = (brightness == 4'hF) || (pwm_cnt < brightness);
  end

  // Shifting the active digits down to the current index leaves only this
  // digit and those above it; all-zero means it is a leading zero.
  always_comb begin
    digits_from_idx = act_digits >> (4 * int'(idx));
    cur_digit       = digits_from_idx[3:0];
    blank           = lz_blank && (idx != '0) && (digits_from_idx == '0);
    seg_nxt         = '0;
    dp_nxt          = 1'b0;
    dig_en_nxt      = '0;
    if (pwm_on) begin
      seg_nxt         = blank ? 7'h00 : seg7_decode(cur_digit);
      dp_nxt          = act_dp[idx];
      dig_en_nxt[idx] = 1'b1;
    end
  end

  // Scan timing: slot counter, PWM phase (restarts every slot) and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      pwm_cnt    <= '0;
      idx        <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fb;
      if (slot_end) begin
        slot_cnt <= '0;
        pwm_cnt  <= '0;
        idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        slot_cnt <= slot_cnt + CNT_W'(1);
        pwm_cnt  <= pwm_cnt + 4'd1;
      end
    end
  end

  // Double buffer: loads land in pending and only reach the displayed copy at
  // a frame boundary; a load coinciding with the boundary bypasses pending.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_digits   <= '0;
      pend_dp       <= '0;
      pending_valid <= 1'b0;
      act_digits    <= '0;
      act_dp        <= '0;
    end else if (fb) begin
      pending_valid <= 1'b0;
      if (load) begin
        act_digits <= digits_in;
        act_dp     <= dp_in;
      end else if (pending_valid) begin
        act_digits <= pend_digits;
        act_dp     <= pend_dp;
      end
    end else if (load) begin
      pend_digits   <= digits_in;
      pend_dp       <= dp_in;
      pending_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg    <= '0;
      dp     <= 1'b0;
      dig_en <= '0;
    end else begin
      seg    <= seg_nxt;
      dp     <= dp_nxt;
      dig_en <= dig_en_nxt;
    end
  end

endmodule
